// File: rtl/chimera_clu_pwr_seq.sv
// chimera_clu_pwr_seq: Chimera PMU cluster power sequencer.
// Sequences one cluster at a time. Power-down runs isolate, clock gate, then reset.
// Power-up runs clock enable under reset, reset release, then de-isolate.
// Optional build macro CHIMERA_PMU_ISO_TIMEOUT_EN bounds each isolation-ack wait to
// IsoTimeout cycles. Without it those waits are unbounded.
module chimera_clu_pwr_seq #(
  parameter int unsigned NumClusters  = 5,
  parameter int unsigned SettleCycles = 4,
  parameter int unsigned RstCycles    = 8,
  parameter int unsigned IsoTimeout   = 255,
  localparam int unsigned IdxW        = (NumClusters > 1) ? $clog2(NumClusters) : 1
) (
  input  logic                   soc_clk_i,
  input  logic                   rst_ni,
  input  logic                   cmd_valid_i,
  output logic                   cmd_ready_o,
  input  logic [IdxW-1:0]        cmd_cluster_i,
  input  logic                   cmd_on_i,
  output logic                   done_o,
  output logic                   done_err_o,
  output logic [NumClusters-1:0] pmu_rst_clusters_no,
  output logic [NumClusters-1:0] pmu_clkgate_en_clusters_o,
  output logic [NumClusters-1:0] pmu_iso_en_clusters_o,
  input  logic [NumClusters-1:0] pmu_iso_ack_clusters_i,
  output logic [NumClusters-1:0] pwr_on_o,
  output logic                   busy_o
);

  localparam int unsigned MaxSr  = (SettleCycles > RstCycles) ? SettleCycles : RstCycles;
  localparam int unsigned MaxCnt = (MaxSr > IsoTimeout) ? MaxSr : IsoTimeout;
  localparam int unsigned CntW   = $clog2(MaxCnt + 1);

  localparam logic [CntW-1:0] SettleLast = CntW'(SettleCycles - 1);
  localparam logic [CntW-1:0] RstLast    = CntW'(RstCycles - 1);
`ifdef CHIMERA_PMU_ISO_TIMEOUT_EN
  localparam logic [CntW-1:0] IsoLast    = CntW'(IsoTimeout - 1);
`endif

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StIsoSet = 3'd1;
  localparam logic [2:0] StGate   = 3'd2;
  localparam logic [2:0] StRstSet = 3'd3;
  localparam logic [2:0] StClkEn  = 3'd4;
  localparam logic [2:0] StRstRel = 3'd5;
  localparam logic [2:0] StIsoRel = 3'd6;
  localparam logic [2:0] StDone   = 3'd7;

  logic [2:0]             state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [IdxW-1:0]        idx_q, idx_d;
  logic                   err_q, err_d;
  logic [NumClusters-1:0] rst_q, rst_d;
  logic [NumClusters-1:0] cg_q, cg_d;
  logic [NumClusters-1:0] iso_q, iso_d;
  logic [NumClusters-1:0] pwr_q, pwr_d;
  logic                   ready_q, ready_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   done_err_q, done_err_d;

  logic [NumClusters-1:0] sel, cmd_sel;
  logic                   cmd_idx_ok, cmd_pwr, ack_sel;

  // One-hot masks for the latched and the incoming cluster index. An
  // out-of-range index yields an all-zero mask, so no bit is ever touched.
  always_comb begin
    sel     = '0;
    cmd_sel = '0;
    for (int unsigned i = 0; i < NumClusters; i++) begin
      sel[i]     = (32'(idx_q) == i);
      cmd_sel[i] = (32'(cmd_cluster_i) == i);
    end
  end

  assign cmd_idx_ok = (32'(cmd_cluster_i) < NumClusters);
  assign cmd_pwr    = |(pwr_q & cmd_sel);
  assign ack_sel    = |(pmu_iso_ack_clusters_i & sel);

  // Next-state logic: sequencing FSM and per-cluster control bits.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    err_d   = err_q;
    rst_d   = rst_q;
    cg_d    = cg_q;
    iso_d   = iso_q;
    pwr_d   = pwr_q;
    case (state_q)
      StIdle: begin
        if (cmd_valid_i && ready_q) begin
          idx_d = cmd_cluster_i;
          err_d = !cmd_idx_ok;
          cnt_d = '0;
          // Bad index or no-op request: report and leave every output alone.
          if (!cmd_idx_ok || (cmd_pwr == cmd_on_i)) begin
            state_d = StDone;
          end else if (cmd_on_i) begin
            state_d = StClkEn;
            cg_d    = cg_q & ~cmd_sel;
            rst_d   = rst_q & ~cmd_sel;
          end else begin
            state_d = StIsoSet;
            iso_d   = iso_q | cmd_sel;
          end
        end
      end
      StIsoSet: begin
        if (ack_sel) begin
          state_d = StGate;
          cg_d    = cg_q | sel;
          cnt_d   = '0;
        end
`ifdef CHIMERA_PMU_ISO_TIMEOUT_EN
        else if (cnt_q == IsoLast) begin
          // Abandon the power-down: drop isolation, cluster stays on.
          state_d = StDone;
          iso_d   = iso_q & ~sel;
          err_d   = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      StGate: begin
        if (cnt_q == SettleLast) begin
          state_d = StRstSet;
          rst_d   = rst_q & ~sel;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRstSet: begin
        if (cnt_q == SettleLast) begin
          state_d = StDone;
          pwr_d   = pwr_q & ~sel;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StClkEn: begin
        if (cnt_q == RstLast) begin
          state_d = StRstRel;
          rst_d   = rst_q | sel;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRstRel: begin
        if (cnt_q == SettleLast) begin
          state_d = StIsoRel;
          iso_d   = iso_q & ~sel;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StIsoRel: begin
        if (!ack_sel) begin
          state_d = StDone;
          pwr_d   = pwr_q | sel;
          cnt_d   = '0;
        end
`ifdef CHIMERA_PMU_ISO_TIMEOUT_EN
        else if (cnt_q == IsoLast) begin
          // Cluster is already clocked and out of reset: count it as on.
          state_d = StDone;
          pwr_d   = pwr_q | sel;
          err_d   = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      StDone: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Registered status outputs derived from the FSM.
  always_comb begin
    ready_d    = (state_d == StIdle);
    busy_d     = (state_d != StIdle);
    done_d     = (state_q == StDone);
    done_err_d = (state_q == StDone) && err_q;
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge soc_clk_i) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      idx_q      <= '0;
      err_q      <= 1'b0;
      rst_q      <= '0;
      cg_q       <= '1;
      iso_q      <= '1;
      pwr_q      <= '0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      done_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      err_q      <= err_d;
      rst_q      <= rst_d;
      cg_q       <= cg_d;
      iso_q      <= iso_d;
      pwr_q      <= pwr_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      done_err_q <= done_err_d;
    end
  end

  assign cmd_ready_o               = ready_q;
  assign busy_o                    = busy_q;
  assign done_o                    = done_q;
  assign done_err_o                = done_err_q;
  assign pmu_rst_clusters_no       = rst_q;
  assign pmu_clkgate_en_clusters_o = cg_q;
  assign pmu_iso_en_clusters_o     = iso_q;
  assign pwr_on_o                  = pwr_q;

endmodule

// File: tb/tb_chimera_clu_pwr_seq.sv
// tb_chimera_clu_pwr_seq: self-checking bench for the cluster power sequencer.
// Directed vector table, randomized commands against a transaction-level model,
// and hand-written sequences for ack timeout/stall, back-pressure and mid-sequence reset.
module tb_chimera_clu_pwr_seq;

  localparam int NC    = 5;
  localparam int SetC  = 4;
  localparam int RstC  = 8;
  localparam int IsoTo = 255;
  localparam logic [NC-1:0] AllOnes = '1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid, cmd_ready, cmd_on;
  logic [2:0]    cmd_cluster;
  logic          done, done_err, busy;
  logic [NC-1:0] rst_no, cg, iso, ack, pwr;

  always #5 clk = ~clk;

  chimera_clu_pwr_seq #(
    .NumClusters (NC),
    .SettleCycles(SetC),
    .RstCycles   (RstC),
    .IsoTimeout  (IsoTo)
  ) u_dut (
    .soc_clk_i                (clk),
    .rst_ni                   (rst_n),
    .cmd_valid_i              (cmd_valid),
    .cmd_ready_o              (cmd_ready),
    .cmd_cluster_i            (cmd_cluster),
    .cmd_on_i                 (cmd_on),
    .done_o                   (done),
    .done_err_o               (done_err),
    .pmu_rst_clusters_no      (rst_no),
    .pmu_clkgate_en_clusters_o(cg),
    .pmu_iso_en_clusters_o    (iso),
    .pmu_iso_ack_clusters_i   (ack),
    .pwr_on_o                 (pwr),
    .busy_o                   (busy)
  );

  // Cluster-side ack model: iso_en looped back through a programmable delay,
  // or forced to a fixed value.
  logic [NC-1:0] iso_hist [16];
  int            ack_dly;
  bit            ack_force;
  logic [NC-1:0] ack_force_val;

  always @(posedge clk) begin
    iso_hist[0] <= iso;
    for (int i = 1; i < 16; i++) iso_hist[i] <= iso_hist[i-1];
  end

  assign ack = ack_force ? ack_force_val : ((ack_dly == 0) ? iso : iso_hist[ack_dly-1]);

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [NC-1:0] m_pwr;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endfunction

  task automatic chk_reset(input string nm);
    chk({nm, " rst_n"},   32'(rst_no), 32'(0));
    chk({nm, " clkgate"}, 32'(cg), 32'(AllOnes));
    chk({nm, " iso"},     32'(iso), 32'(AllOnes));
    chk({nm, " pwr_on"},  32'(pwr), 32'(0));
    chk({nm, " done"},    32'(done), 32'(0));
    chk({nm, " done_err"}, 32'(done_err), 32'(0));
    chk({nm, " busy"},    32'(busy), 32'(0));
    chk({nm, " ready"},   32'(cmd_ready), 32'(0));
  endtask

  // Issue one command, measure accept-to-done latency and the length of the
  // clock/reset window on the target cluster, then check the final outputs.
  task automatic run_cmd(input int cl, input bit on, input int dly, input bit exp_err,
                         input int exp_lat, input int exp_win, input logic [NC-1:0] e_pwr,
                         input logic [NC-1:0] e_rst, input logic [NC-1:0] e_cg,
                         input logic [NC-1:0] e_iso, input string nm);
    int       n;
    int       win;
    int       guard;
    bit       seen;
    bit [2:0] bi;
    bi      = 3'(cl);
    ack_dly = dly;
    guard   = 0;
    while (!cmd_ready && guard < 64) begin
      @(negedge clk);
      guard++;
    end
    chk({nm, " ready"}, 32'(cmd_ready), 32'(1));
    cmd_cluster = bi;
    cmd_on      = on;
    cmd_valid   = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    n    = 0;
    win  = 0;
    seen = 1'b0;
    while (!seen && n < 2000) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        if (cl < NC) begin
          if (on ? (!cg[bi] && !rst_no[bi]) : (cg[bi] && rst_no[bi])) win++;
        end
        @(negedge clk);
        n++;
      end
    end
    chk({nm, " latency"}, seen ? n : -1, exp_lat);
    chk({nm, " done_err"}, 32'(done_err), 32'(exp_err));
    chk({nm, " pwr_on"},  32'(pwr), 32'(e_pwr));
    chk({nm, " rst_n"},   32'(rst_no), 32'(e_rst));
    chk({nm, " clkgate"}, 32'(cg), 32'(e_cg));
    chk({nm, " iso"},     32'(iso), 32'(e_iso));
    if (exp_win >= 0) chk({nm, " window"}, win, exp_win);
    @(negedge clk);
    chk({nm, " done width"}, 32'(done), 32'(0));
    repeat (16) @(negedge clk);
  endtask

  // Reference model at command level: a powered cluster is out of reset,
  // clocked and de-isolated; an unpowered one is the opposite.
  task automatic model_cmd(input int cl, input bit on, input int d, input string nm);
    bit            err;
    int            lat;
    int            win;
    logic [NC-1:0] p;
    p = m_pwr;
    if (cl >= NC) begin
      err = 1'b1; lat = 1; win = -1;
    end else if (m_pwr[3'(cl)] == on) begin
      err = 1'b0; lat = 1; win = 0;
    end else begin
      err = 1'b0;
      p[3'(cl)] = on;
      lat = on ? (RstC + SetC + 2 + d) : (2 * SetC + 2 + d);
      win = on ? RstC : SetC;
    end
    m_pwr = p;
    run_cmd(cl, on, d, err, lat, win, p, p, ~p, ~p, nm);
  endtask

  typedef struct {
    int            cl;
    bit            on;
    int            dly;
    bit            err;
    int            lat;
    int            win;
    logic [NC-1:0] pwr;
  } vec_t;

  vec_t tbl [10];

  initial begin
    int cl;
    int d;
    bit on;
    int n;
    int rdy_seen;
    int dcnt;

    tbl[0] = '{2, 1'b1, 0,  1'b0, 14, 8,  5'b00100};
    tbl[1] = '{2, 1'b1, 0,  1'b0, 1,  0,  5'b00100};
    tbl[2] = '{7, 1'b1, 0,  1'b1, 1,  -1, 5'b00100};
    tbl[3] = '{2, 1'b0, 10, 1'b0, 20, 4,  5'b00000};
    tbl[4] = '{4, 1'b0, 0,  1'b0, 1,  0,  5'b00000};
    tbl[5] = '{0, 1'b1, 3,  1'b0, 17, 8,  5'b00001};
    tbl[6] = '{4, 1'b1, 0,  1'b0, 14, 8,  5'b10001};
    tbl[7] = '{5, 1'b0, 0,  1'b1, 1,  -1, 5'b10001};
    tbl[8] = '{0, 1'b0, 1,  1'b0, 11, 4,  5'b10000};
    tbl[9] = '{3, 1'b1, 5,  1'b0, 19, 8,  5'b11000};

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_cluster = '0; cmd_on = 1'b0;
    ack_force = 1'b0; ack_force_val = '0; ack_dly = 0; m_pwr = '0;

    repeat (3) @(negedge clk);
    chk_reset("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready after reset", 32'(cmd_ready), 32'(1));
    repeat (16) @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      run_cmd(tbl[i].cl, tbl[i].on, tbl[i].dly, tbl[i].err, tbl[i].lat, tbl[i].win,
              tbl[i].pwr, tbl[i].pwr, ~tbl[i].pwr, ~tbl[i].pwr, $sformatf("vec%0d", i));
    end
    m_pwr = tbl[9].pwr;

    for (int t = 0; t < 30; t++) begin
      cl = int'($urandom_range(0, 6));
      on = 1'($urandom_range(0, 1));
      d  = int'($urandom_range(0, 5));
      model_cmd(cl, on, d, $sformatf("rnd%0d", t));
    end

`ifdef CHIMERA_PMU_ISO_TIMEOUT_EN
    // Stuck-low ack on power-down, then stuck-high ack on power-up.
    model_cmd(0, 1'b1, 0, "to pre0");
    ack_force_val = '0;
    ack_force     = 1'b1;
    run_cmd(0, 1'b0, 0, 1'b1, IsoTo + 1, 0, m_pwr, m_pwr, ~m_pwr, ~m_pwr, "iso_set timeout");
    ack_force = 1'b0;
    repeat (16) @(negedge clk);
    model_cmd(3, 1'b0, 0, "to pre3");
    ack_force_val = '1;
    ack_force     = 1'b1;
    m_pwr[3]      = 1'b1;
    run_cmd(3, 1'b1, 0, 1'b1, RstC + SetC + IsoTo + 1, RstC, m_pwr, m_pwr, ~m_pwr, ~m_pwr,
            "iso_rel timeout");
    ack_force = 1'b0;
    repeat (16) @(negedge clk);
`else
    // Ack wait must not give up on its own.
    model_cmd(0, 1'b1, 0, "unb pre0");
    ack_force_val = '0;
    ack_force     = 1'b1;
    cmd_cluster   = 3'd0;
    cmd_on        = 1'b0;
    cmd_valid     = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    dcnt = 0;
    repeat (300) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    chk("unbounded busy", 32'(busy), 32'(1));
    chk("unbounded no done", dcnt, 0);
    chk("unbounded iso0", 32'(iso[0]), 32'(1));
    ack_force = 1'b0;
    ack_dly   = 0;
    n = 0;
    while (!done && n < 50) begin
      @(negedge clk);
      n++;
    end
    m_pwr[0] = 1'b0;
    chk("unbounded resume latency", n, 2 * SetC + 2);
    chk("unbounded resume err", 32'(done_err), 32'(0));
    chk("unbounded resume pwr", 32'(pwr), 32'(m_pwr));
    repeat (16) @(negedge clk);
`endif

    // Back-pressure: second command held while the first one runs.
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset("idle reset");
    rst_n   = 1'b1;
    m_pwr   = '0;
    ack_dly = 0;
    repeat (16) @(negedge clk);
    cmd_cluster = 3'd1;
    cmd_on      = 1'b1;
    cmd_valid   = 1'b1;
    @(negedge clk);
    cmd_cluster = 3'd3;
    n = 0;
    rdy_seen = 0;
    while (!done && n < 100) begin
      if (cmd_ready) rdy_seen++;
      @(negedge clk);
      n++;
    end
    chk("stall ready low", rdy_seen, 0);
    chk("stall first latency", n, RstC + SetC + 2);
    chk("stall first pwr", 32'(pwr), 32'(5'b00010));
    chk("stall ready at idle", 32'(cmd_ready), 32'(1));
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("second accepted busy", 32'(busy), 32'(1));
    chk("second clkgate3", 32'(cg[3]), 32'(0));
    chk("second rst3", 32'(rst_no[3]), 32'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset("mid clk_en reset");
    dcnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    chk("no done after abort", dcnt, 0);
    chk("abort pwr stays off", 32'(pwr), 32'(0));
    chk("abort idle", 32'(busy), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
